seg_scan_driver: RTL and testbench

Time-multiplexed N-digit seven-segment driver and the parametrised successor to the single-digit combinational decoder. It scans the digits one at a time through a shared segment bus and a one-hot anode bus. It adds a full hex or decimal-only glyph set, per-digit blanking, per-digit blink, a per-digit decimal point, and anti-ghosting dead time between digits. It sits between the counter/datapath logic and the board display pins.

---
 rtl/seg_pkg.sv | 61 ++++++
 rtl/seg7_decoder.sv | 20 ++
 rtl/seg_scan_driver.sv | 149 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ============================================================================
// Module      : seg_pkg
// Description : Seven-segment glyph type, glyph constants and decode function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    typedef logic [6:0] seg7_glyph_t;

    localparam seg7_glyph_t SEG_0    = 7'h3F;
    localparam seg7_glyph_t SEG_1    = 7'h06;
    localparam seg7_glyph_t SEG_2    = 7'h5B;
    localparam seg7_glyph_t SEG_3    = 7'h4F;
    localparam seg7_glyph_t SEG_4    = 7'h66;
    localparam seg7_glyph_t SEG_5    = 7'h6D;
    localparam seg7_glyph_t SEG_6    = 7'h7D;
    localparam seg7_glyph_t SEG_7    = 7'h07;
    localparam seg7_glyph_t SEG_8    = 7'h7F;
    localparam seg7_glyph_t SEG_9    = 7'h6F;
    localparam seg7_glyph_t SEG_A    = 7'h77;
    localparam seg7_glyph_t SEG_B    = 7'h7C;
    localparam seg7_glyph_t SEG_C    = 7'h39;
    localparam seg7_glyph_t SEG_D    = 7'h5E;
    localparam seg7_glyph_t SEG_E    = 7'h79;
    localparam seg7_glyph_t SEG_F    = 7'h71;
    localparam seg7_glyph_t SEG_DASH = 7'h40;
    localparam seg7_glyph_t SEG_OFF  = 7'h00;

    function automatic seg7_glyph_t seg7_decode(input logic [3:0] nibble,
                                                input logic       decimal_only);
        seg7_glyph_t glyph;
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        if (decimal_only && (nibble > 4'd9)) begin
            glyph = SEG_DASH;
        end
        return glyph;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decoder.sv
// ============================================================================
// Module      : seg7_decoder
// Description : Combinational nibble to active-high seven-segment glyph.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_decoder
    import seg_pkg::*;
(
    input  logic [3:0]  nibble_i,
    input  logic        decimal_only_i,
    output seg7_glyph_t seg_o
);

    assign seg_o = seg7_decode(nibble_i, decimal_only_i);

endmodule

`default_nettype wire

// File: rtl/seg_scan_driver.sv
// ============================================================================
// Module      : seg_scan_driver
// Description : Time-multiplexed N-digit seven-segment scanner with blanking,
//               blink, decimal point and anti-ghosting dead time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int          NUM_DIGITS     = 4,
    parameter logic [15:0] REFRESH_CYCLES = 16'd50000,
    parameter int          DEAD_CYCLES    = 4,
    parameter int          BLINK_SCANS    = 50,
    parameter bit          DECIMAL_ONLY   = 1'b0,
    parameter bit          ACTIVE_LOW_OUT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int REFRESH_N = int'(REFRESH_CYCLES);
    localparam int SLOT_W    = (REFRESH_N > 1)   ? $clog2(REFRESH_N)   : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int SCAN_W    = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(REFRESH_N - 1);
    localparam logic [SLOT_W-1:0]     DEAD_THR  = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(BLINK_SCANS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW_OUT}};
    localparam seg7_glyph_t           SEG_INACT = {7{ACTIVE_LOW_OUT}};

    logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic                  blink_phase_q, blink_phase_d;
    logic [3:0]            nib_q, nib_d;
    logic                  blank_q, blank_d;
    logic                  blink_q, blink_d;
    logic                  dp_lat_q, dp_lat_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg7_glyph_t           seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  w_slot_wrap;
    logic                  w_idx_wrap;
    logic                  w_capture;
    logic                  w_in_dead;
    logic                  w_lit;
    seg7_glyph_t           w_glyph;

    assign w_slot_wrap = (slot_cnt_q == SLOT_LAST);
    assign w_idx_wrap  = w_slot_wrap && (idx_q == IDX_LAST);
    assign w_capture   = (slot_cnt_q == '0);
    assign w_in_dead   = (DEAD_CYCLES > 0) && (slot_cnt_q < DEAD_THR);

    // The capture cycle sees the incoming values directly, so a zero dead
    // time never shows the previous digit's glyph under the new anode.
    always_comb begin
        nib_d    = nib_q;
        blank_d  = blank_q;
        blink_d  = blink_q;
        dp_lat_d = dp_lat_q;
        if (w_capture) begin
            nib_d    = digits[{idx_q, 2'b00} +: 4];
            blank_d  = blank_mask[idx_q];
            blink_d  = blink_mask[idx_q];
            dp_lat_d = dp_in[idx_q];
        end
    end

    seg7_decoder u_decoder (
        .nibble_i       (nib_d),
        .decimal_only_i (DECIMAL_ONLY),
        .seg_o          (w_glyph)
    );

    assign w_lit = !w_in_dead && !blank_d && !(blink_d && blink_phase_q);

    always_comb begin
        slot_cnt_d    = w_slot_wrap ? '0 : slot_cnt_q + 1'b1;
        idx_d         = idx_q;
        scan_cnt_d    = scan_cnt_q;
        blink_phase_d = blink_phase_q;
        if (w_slot_wrap) begin
            idx_d = w_idx_wrap ? '0 : idx_q + 1'b1;
        end
        if (w_idx_wrap) begin
            scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
            blink_phase_d = blink_phase_q ^ (scan_cnt_q == SCAN_LAST);
        end
    end

    // Polarity is applied by XOR so lit and dark share one expression.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_INACT;
        dp_d  = ACTIVE_LOW_OUT;
        if (w_lit) begin
            an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
            seg_d = w_glyph ^ SEG_INACT;
            dp_d  = dp_lat_d ^ ACTIVE_LOW_OUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            idx_q         <= '0;
            scan_cnt_q    <= '0;
            blink_phase_q <= 1'b0;
            nib_q         <= 4'h0;
            blank_q       <= 1'b1;
            blink_q       <= 1'b0;
            dp_lat_q      <= 1'b0;
            an_q          <= AN_OFF;
            seg_q         <= SEG_INACT;
            dp_q          <= ACTIVE_LOW_OUT;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            idx_q         <= idx_d;
            scan_cnt_q    <= scan_cnt_d;
            blink_phase_q <= blink_phase_d;
            nib_q         <= nib_d;
            blank_q       <= blank_d;
            blink_q       <= blink_d;
            dp_lat_q      <= dp_lat_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Directed self-checking bench for seg_scan_driver (4 digits,
//               8-cycle slots, 2 dead cycles, 2 scans per blink half-period).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [6:0]  seg, seg_dec;
    logic        dp, dp_dec;
    logic [3:0]  an, an_dec;

    int n_checks = 0;
    int n_errors = 0;

    // {an, seg, dp} with every output inactive (active-low board)
    localparam logic [11:0] OFF = 12'hFFF;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
                                          7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C,
                                          7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_CYCLES(16'd8), .DEAD_CYCLES(2),
        .BLINK_SCANS(2), .DECIMAL_ONLY(1'b0), .ACTIVE_LOW_OUT(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .dp_in(dp_in), .seg(seg), .dp(dp), .an(an)
    );

    seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_CYCLES(16'd8), .DEAD_CYCLES(2),
        .BLINK_SCANS(2), .DECIMAL_ONLY(1'b1), .ACTIVE_LOW_OUT(1'b1)
    ) dut_dec (
        .clk(clk), .rst_n(rst_n), .digits(digits), .blank_mask(blank_mask),
        .blink_mask(blink_mask), .dp_in(dp_in), .seg(seg_dec), .dp(dp_dec), .an(an_dec)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {an,seg,dp} during the cycle after edge t, where c = t-1 is the
    // number of edges since reset release that the registered outputs reflect.
    function automatic logic [11:0] expect_out(input int c, input bit dec);
        int         slot;
        int         idx;
        int         phase;
        logic [3:0] nib;
        logic [6:0] g;
        logic       lit;
        slot  = c % 8;
        idx   = (c / 8) % 4;
        phase = (c / 64) % 2;
        nib   = digits[idx*4 +: 4];
        g     = GLYPH[nib];
        if (dec && nib > 4'd9) g = 7'h40;
        lit = (slot >= 2) && !blank_mask[idx] && !(blink_mask[idx] && phase == 1);
        if (!lit) return OFF;
        return {~(4'b0001 << idx), ~g, ~dp_in[idx]};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed an/seg/dp=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic check_onehot(input string tag, input logic [3:0] a);
        n_checks++;
        assert ($countones(~a) <= 1) else begin
            n_errors++;
            $error("FAIL %s: observed an=%h required at most one zero", tag, a);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset, then release between edges so the next edge is t=1.
    task automatic restart();
        rst_n = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic run_model(input string tag, input int n);
        for (int t = 1; t <= n; t++) begin
            step();
            check($sformatf("%s t=%0d", tag, t), {an, seg, dp}, expect_out(t - 1, 1'b0));
            check($sformatf("%s dec t=%0d", tag, t), {an_dec, seg_dec, dp_dec},
                  expect_out(t - 1, 1'b1));
            check_onehot($sformatf("%s onehot t=%0d", tag, t), an);
        end
    endtask

    initial begin
        // Reset held while clocking
        digits = 16'h1234;
        repeat (3) step();
        check("reset_hold", {an, seg, dp}, OFF);
        check("reset_hold_dec", {an_dec, seg_dec, dp_dec}, OFF);
        #2;
        rst_n = 1'b1;

        // Plain scan of 1234, one full scan plus part of the next
        run_model("scan1234", 40);
        check("pre_async_digit0", {an, seg, dp}, {4'hE, 7'h19, 1'b1});

        // Asynchronous reset mid-slot, checked before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {an, seg, dp}, OFF);
        check("async_reset_dec", {an_dec, seg_dec, dp_dec}, OFF);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        step();
        step();
        check("restart_digit0", {an, seg, dp}, {4'hE, 7'h19, 1'b1});

        // Hex letters versus decimal-only dash
        digits = 16'h00AF;
        restart();
        run_model("hexAF", 16);

        // Blanked digit 3 and decimal point on digit 1
        digits     = 16'h1234;
        blank_mask = 4'b1000;
        dp_in      = 4'b0010;
        restart();
        run_model("blank_dp", 32);

        // Blink on digit 0 across six scans
        blank_mask = 4'b0000;
        dp_in      = 4'b0000;
        blink_mask = 4'b0001;
        restart();
        run_model("blink", 193);

        // Mid-slot input change while digit 2 is displayed
        blink_mask = 4'b0000;
        digits     = 16'h1234;
        restart();
        run_model("midslot_pre", 20);
        digits = 16'h5678;
        for (int t = 21; t <= 24; t++) begin
            step();
            check($sformatf("midslot_hold t=%0d", t), {an, seg, dp}, {4'hB, 7'h24, 1'b1});
        end
        step();
        check("midslot_dead25", {an, seg, dp}, OFF);
        step();
        check("midslot_dead26", {an, seg, dp}, OFF);
        step();
        check("midslot_digit3_new", {an, seg, dp}, {4'h7, 7'h12, 1'b1});
        repeat (8) step();
        check("midslot_digit0_new", {an, seg, dp}, {4'hE, 7'h00, 1'b1});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
